// File: rtl/aone_pia_ctrl.sv
// Apple-1 PIA-style terminal controller: keyboard FIFO presented as KBD/KBDCR,
// and DSP writes turned into a paced valid/ready character stream.
module aone_pia_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hD010,
  parameter int          KBD_DEPTH = 8,
  parameter int          DSP_DELAY = 16,
  parameter bit          UPCASE    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        hit,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [6:0]  dsp_data,
  output logic        dsp_valid,
  input  logic        dsp_ready,
  output logic        dsp_ovr
);

  localparam int AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam int CW = (DSP_DELAY > 1) ? $clog2(DSP_DELAY + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SEND} dsp_state_e;
  typedef enum logic [1:0] {REG_KBD, REG_KBDCR, REG_DSP, REG_DSPCR} reg_e;

  logic [6:0]    fifo_mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    last_key;
  logic [6:0]    kbdcr_ctl;
  logic [6:0]    dspcr_hi;
  logic [CW-1:0] cnt, cnt_next;
  dsp_state_e    state, state_next;

  reg_e       offset;
  logic       wr_en, rd_en, empty, full, push, pop, busy, dsp_write;
  logic [6:0] head;
  logic [7:0] rdata;

  // Keystrokes are normalised once on entry so every reader sees the same code.
  function automatic logic [6:0] map_key(input logic [7:0] raw);
    logic [7:0] b;
    b = raw & 8'h7F;
    if (b == 8'h0A) b = 8'h0D;
    if (UPCASE && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
    return b[6:0];
  endfunction

  assign hit       = (address[15:2] == BASE_ADDR[15:2]);
  assign offset    = reg_e'(address[1:0]);
  assign wr_en     = hit && mem_write;
  assign rd_en     = hit && mem_read && !mem_write;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(KBD_DEPTH));
  assign kbd_ready = !full;
  assign push      = kbd_valid && !full;
  assign pop       = rd_en && (offset == REG_KBD) && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign dsp_write = wr_en && (offset == REG_DSP);
  assign dsp_valid = (state == SEND);

  // NOTE: the FIFO storage has no reset; count/pointers alone define what is valid,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= map_key(kbd_data);
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, matching the read data the CPU saw in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_key <= 8'h80;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_key <= {1'b1, head};
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kbdcr_ctl <= '0;
      dspcr_hi  <= '0;
      dsp_data  <= '0;
      dsp_ovr   <= 1'b0;
    end else begin
      if (wr_en && offset == REG_KBDCR) kbdcr_ctl <= data_in[6:0];
      if (wr_en && offset == REG_DSPCR) dspcr_hi <= data_in[7:1];
      if (dsp_write && !busy) dsp_data <= data_in[6:0];
      if (dsp_write && busy) dsp_ovr <= 1'b1;
      else if (wr_en && offset == REG_DSPCR && data_in[0]) dsp_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first in every combinational block so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: if (dsp_write) begin
        cnt_next   = CW'(DSP_DELAY);
        state_next = (DSP_DELAY == 0) ? SEND : HOLD;
      end
      HOLD: begin
        cnt_next = cnt - 1'b1;
        if (cnt <= CW'(1)) state_next = SEND;
      end
      SEND:    if (dsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (offset)
      REG_KBD:   rdata = empty ? last_key : {1'b1, head};
      REG_KBDCR: rdata = {!empty, kbdcr_ctl};
      REG_DSP:   rdata = {busy, 7'b0};
      REG_DSPCR: rdata = {dspcr_hi, 1'b0};
      default:   rdata = '0;
    endcase
  end

  assign data_out = (hit && mem_read) ? rdata : 8'h00;

endmodule

// File: tb/tb_aone_pia_ctrl.sv
// Directed bench for aone_pia_ctrl with hand-computed expectations (default parameters).
module tb_aone_pia_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0000;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        hit;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready;
  logic [6:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready = 1'b0;
  logic        dsp_ovr;

  int n_checks = 0;
  int n_fails  = 0;
  int cycles;

  aone_pia_ctrl dut (
    .clk(clk), .reset_n(reset_n), .address(address), .mem_read(mem_read),
    .mem_write(mem_write), .data_in(data_in), .data_out(data_out), .hit(hit),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_ovr(dsp_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    address  = a;
    mem_read = 1'b1;
    #1 check(tag, data_out, exp);
    @(posedge clk);
    #1 mem_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    address   = a;
    data_in   = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] b);
    @(negedge clk);
    kbd_data  = b;
    kbd_valid = 1'b1;
    @(posedge clk);
    #1 kbd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("rst_kbd_ready", {7'b0, kbd_ready}, 8'h01);
    check("rst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("rst_dsp_data",  {1'b0, dsp_data},  8'h00);
    check("rst_dsp_ovr",   {7'b0, dsp_ovr},   8'h00);
    cpu_read(16'hD011, 8'h00, "rst_kbdcr");
    cpu_read(16'hD010, 8'h80, "rst_kbd");
    cpu_read(16'hD010, 8'h80, "rst_kbd_empty_pop");

    // Address decode
    @(negedge clk);
    address  = 16'hD014;
    mem_read = 1'b1;
    #1;
    check("miss_hit",  {7'b0, hit}, 8'h00);
    check("miss_data", data_out,    8'h00);
    address = 16'hD013;
    #1 check("hit_d013", {7'b0, hit}, 8'h01);
    @(posedge clk);
    #1 mem_read = 1'b0;

    // Lowercase mapping and LF->CR
    push_key(8'h61);
    push_key(8'h0A);
    cpu_read(16'hD011, 8'h80, "kbdcr_ready");
    cpu_read(16'hD010, 8'hC1, "pop_a");
    cpu_read(16'hD010, 8'h8D, "pop_cr");
    cpu_read(16'hD011, 8'h00, "kbdcr_drained");
    cpu_read(16'hD010, 8'h8D, "last_key_hold");

    // KBDCR control bits and ignored KBD write
    cpu_write(16'hD011, 8'hFF);
    cpu_read(16'hD011, 8'h7F, "kbdcr_ctl");
    cpu_write(16'hD011, 8'h00);
    cpu_write(16'hD010, 8'h12);
    cpu_read(16'hD010, 8'h8D, "kbd_write_ignored");

    // Fill FIFO across the pointer wrap; mapping of boundary characters
    push_key(8'h31); push_key(8'hE1); push_key(8'h7B); push_key(8'h60);
    push_key(8'h7A); push_key(8'h0A); push_key(8'h41);
    check("ready_before_full", {7'b0, kbd_ready}, 8'h01);
    push_key(8'h20);
    check("full_not_ready", {7'b0, kbd_ready}, 8'h00);
    push_key(8'h55);
    cpu_read(16'hD010, 8'hB1, "fifo0");
    check("ready_after_pop", {7'b0, kbd_ready}, 8'h01);
    cpu_read(16'hD010, 8'hC1, "fifo1_bit7_masked");
    cpu_read(16'hD010, 8'hFB, "fifo2_brace");
    cpu_read(16'hD010, 8'hE0, "fifo3_backtick");
    cpu_read(16'hD010, 8'hDA, "fifo4_z");
    cpu_read(16'hD010, 8'h8D, "fifo5_cr");
    cpu_read(16'hD010, 8'hC1, "fifo6_A");
    cpu_read(16'hD010, 8'hA0, "fifo7_space");
    cpu_read(16'hD011, 8'h00, "fifo_empty_after_8");
    cpu_read(16'hD010, 8'hA0, "ninth_dropped");

    // Read and write in the same cycle: no pop
    push_key(8'h42);
    @(negedge clk);
    address = 16'hD010; data_in = 8'h00; mem_read = 1'b1; mem_write = 1'b1;
    @(posedge clk);
    #1 begin mem_read = 1'b0; mem_write = 1'b0; end
    cpu_read(16'hD011, 8'h80, "rw_no_pop");
    cpu_read(16'hD010, 8'hC2, "rw_key_kept");

    // Push and pop on the same edge
    push_key(8'h43);
    @(negedge clk);
    address = 16'hD010; mem_read = 1'b1; kbd_data = 8'h44; kbd_valid = 1'b1;
    #1 check("pushpop_read", data_out, 8'hC3);
    @(posedge clk);
    #1 begin mem_read = 1'b0; kbd_valid = 1'b0; end
    cpu_read(16'hD011, 8'h80, "pushpop_count");
    cpu_read(16'hD010, 8'hC4, "pushpop_new");
    cpu_read(16'hD011, 8'h00, "pushpop_empty");

    // Display path: latency, busy, overrun
    dsp_ready = 1'b0;
    cpu_write(16'hD012, 8'hC5);
    check("dsp_not_yet", {7'b0, dsp_valid}, 8'h00);
    cpu_read(16'hD012, 8'h80, "dsp_busy");
    cycles = 1;
    while (!dsp_valid && cycles < 40) begin
      @(posedge clk);
      #1 cycles++;
    end
    check("dsp_latency", 8'(cycles + 1), 8'd17);
    check("dsp_data", {1'b0, dsp_data}, 8'h45);
    cpu_write(16'hD012, 8'h33);
    check("dsp_ovr_set", {7'b0, dsp_ovr}, 8'h01);
    check("dsp_data_kept", {1'b0, dsp_data}, 8'h45);
    check("dsp_still_valid", {7'b0, dsp_valid}, 8'h01);
    cpu_write(16'hD013, 8'h06);
    cpu_read(16'hD013, 8'h06, "dspcr_rw");
    @(negedge clk) dsp_ready = 1'b1;
    @(posedge clk);
    #1 dsp_ready = 1'b0;
    check("dsp_accepted", {7'b0, dsp_valid}, 8'h00);
    cpu_read(16'hD012, 8'h00, "dsp_idle");
    check("dsp_data_after", {1'b0, dsp_data}, 8'h45);
    check("ovr_sticky", {7'b0, dsp_ovr}, 8'h01);
    cpu_write(16'hD013, 8'h01);
    check("ovr_cleared", {7'b0, dsp_ovr}, 8'h00);
    cpu_read(16'hD013, 8'h00, "dspcr_bit0_not_stored");

    // Asynchronous reset in the middle of SEND with keys queued
    push_key(8'h31); push_key(8'h32); push_key(8'h33);
    cpu_write(16'hD012, 8'h21);
    cycles = 0;
    while (!dsp_valid && cycles < 40) begin
      @(posedge clk);
      #1 cycles++;
    end
    check("mid_send_valid", {7'b0, dsp_valid}, 8'h01);
    @(negedge clk);
    address = 16'hD011; mem_read = 1'b1;
    #1 check("pre_reset_kbdcr", data_out, 8'h80);
    #1 reset_n = 1'b0;
    #1;
    check("arst_dsp_valid", {7'b0, dsp_valid}, 8'h00);
    check("arst_kbdcr",     data_out,          8'h00);
    check("arst_dsp_data",  {1'b0, dsp_data},  8'h00);
    check("arst_kbd_ready", {7'b0, kbd_ready}, 8'h01);
    @(posedge clk);
    #1 mem_read = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    cpu_read(16'hD010, 8'h80, "post_reset_kbd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
